// File: rtl/adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder used once per cycle by the
// serial adder. c_msb exposes the carry into the top bit so the caller can
// form signed overflow on the most significant chunk.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] w_c;

   // Ripple the carry bit by bit through the chunk.
   always_comb begin
      w_c    = '0;
      s      = '0;
      w_c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]     = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
      end
   end

   assign co    = w_c[CHUNK];
   assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle WIDTH-bit adder: adds CHUNK bits per clock, carrying between
// chunks in a 1-bit register. Valid/ready on both sides; one addition takes
// an accept cycle, NCHUNK add cycles and at least one DONE cycle.
module chunk_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   // Reject illegal parameter combinations at elaboration.
   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_chk
      $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [CHUNK-1:0]   w_a_chunk;
   logic [CHUNK-1:0]   w_b_chunk;
   logic [CHUNK-1:0]   w_s;
   logic               w_co;
   logic               w_c_msb;
   logic               w_last;

   // Select the operand chunk currently being added.
   assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
   assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
   assign w_last    = (r_idx == LAST_IDX);

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a     (w_a_chunk),
      .b     (w_b_chunk),
      .ci    (r_carry),
      .s     (w_s),
      .co    (w_co),
      .c_msb (w_c_msb)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: accept in IDLE, step through chunks, hold in DONE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (in_valid)  w_next = ADD;
         ADD:  if (w_last)    w_next = DONE;
         DONE: if (out_ready) w_next = IDLE;
         default:             w_next = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, accumulate one chunk per ADD cycle,
   // capture carry/overflow from the most significant chunk. Nothing is
   // written in DONE so the result stays frozen under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
               end
            end
            ADD: begin
               r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
               r_carry <= w_co;
               if (w_last) begin
                  // Index parks at zero so the operand mux never leaves range.
                  r_idx  <= '0;
                  r_cout <= w_co;
                  r_ovf  <= w_c_msb ^ w_co;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: three instances (32/8, 8/2, 16/16)
// driven from a vector table, an 8-bit operand sweep against a reference
// sum, plus backpressure and mid-operation reset sequences on the 32-bit one.
module tb_chunk_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // 32-bit / 8-bit chunks
   logic        iv32 = 0, ir32, cin32 = 0, ov32, or32 = 0, co32, of32;
   logic [31:0] a32 = 0, b32 = 0, s32;
   // 8-bit / 2-bit chunks
   logic        iv8 = 0, ir8, cin8 = 0, ov8, or8 = 0, co8, of8;
   logic [7:0]  a8 = 0, b8 = 0, s8;
   // 16-bit / single chunk
   logic        iv16 = 0, ir16, cin16 = 0, ov16, or16 = 0, co16, of16;
   logic [15:0] a16 = 0, b16 = 0, s16;

   chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .overflow(of32));
   chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .overflow(of8));
   chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .overflow(of16));

   int n_chk = 0;
   int n_err = 0;
   int n_xfer32 = 0;

   always @(posedge clk) if (ov32 && or32) n_xfer32 <= n_xfer32 + 1;

   typedef struct {
      int          inst;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int inst, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      case (inst)
         0: begin iv32 = v; a32 = a;        b32 = b;        cin32 = c; end
         1: begin iv8  = v; a8  = a[7:0];   b8  = b[7:0];   cin8  = c; end
         default: begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; cin16 = c; end
      endcase
   endtask

   task automatic set_ordy(input int inst, input logic v);
      case (inst)
         0: or32 = v;
         1: or8 = v;
         default: or16 = v;
      endcase
   endtask

   function automatic logic get_ov(input int inst);
      case (inst)
         0: return ov32;
         1: return ov8;
         default: return ov16;
      endcase
   endfunction

   function automatic logic [33:0] get_res(input int inst);
      case (inst)
         0: return {of32, co32, s32};
         1: return {of8, co8, 24'd0, s8};
         default: return {of16, co16, 16'd0, s16};
      endcase
   endfunction

   // One full transaction: accept, count edges to out_valid, take result.
   task automatic do_add(input int inst, input logic [31:0] a, input logic [31:0] b,
                         input logic c, output logic [33:0] res, output int lat);
      @(negedge clk);
      drive(inst, 1'b1, a, b, c);
      @(posedge clk);
      #1 drive(inst, 1'b0, 32'd0, 32'd0, 1'b0);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (get_ov(inst)) break;
      end
      res = get_res(inst);
      @(negedge clk) set_ordy(inst, 1'b1);
      @(posedge clk);
      #1 set_ordy(inst, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [33:0] res;
      int          lat;
      logic [8:0]  t9;
      logic [7:0]  ua, ub;
      logic        eovf;
      logic        seen_ov;
      logic        stable;
      logic        rdy_low;
      int          xb;

      vecs[0]  = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 4};
      vecs[1]  = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 4};
      vecs[2]  = '{0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 4};
      vecs[3]  = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 4};
      vecs[4]  = '{0, 32'h000000FF, 32'h00000001, 1'b1, 32'h00000101, 1'b0, 1'b0, 4};
      vecs[5]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 4};
      vecs[6]  = '{0, 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 4};
      vecs[7]  = '{2, 32'h00008000, 32'h00008000, 1'b1, 32'h00000001, 1'b1, 1'b1, 1};
      vecs[8]  = '{2, 32'h00007FFF, 32'h00000000, 1'b1, 32'h00008000, 1'b0, 1'b1, 1};
      vecs[9]  = '{2, 32'h00001234, 32'h00004321, 1'b0, 32'h00005555, 1'b0, 1'b0, 1};
      vecs[10] = '{1, 32'h000000FF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 4};
      vecs[11] = '{1, 32'h0000007F, 32'h0000007F, 1'b0, 32'h000000FE, 1'b0, 1'b1, 4};
      vecs[12] = '{1, 32'h00000080, 32'h000000FF, 1'b0, 32'h0000007F, 1'b1, 1'b1, 4};
      vecs[13] = '{1, 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 4};

      // Reset state
      #2;
      chk("reset in_ready",  {63'd0, ir32}, 64'd1);
      chk("reset out_valid", {63'd0, ov32}, 64'd0);
      chk("reset sum/cout/ovf", {30'd0, of32, co32, s32}, 64'd0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 14; i++) begin
         do_add(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].cin, res, lat);
         chk($sformatf("vec%0d result", i), {30'd0, res},
             {30'd0, vecs[i].ovf, vecs[i].cout, vecs[i].sum});
         chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      end

      // 8-bit operand sweep against a reference a+b+cin
      for (int ia = 0; ia < 256; ia += 5) begin
         for (int ib = 0; ib < 256; ib += 15) begin
            for (int c = 0; c < 2; c++) begin
               ua   = 8'(ia);
               ub   = 8'(ib);
               t9   = {1'b0, ua} + {1'b0, ub} + 9'(c);
               eovf = (ua[7] == ub[7]) && (t9[7] != ua[7]);
               do_add(1, {24'd0, ua}, {24'd0, ub}, c[0], res, lat);
               chk($sformatf("sweep %02h+%02h+%0d", ua, ub, c), {30'd0, res[33:32], 24'd0, res[7:0], 8'(lat)},
                   {30'd0, eovf, t9[8], 24'd0, t9[7:0], 8'd4});
            end
         end
      end

      // Backpressure: hold DONE for 10 cycles while inputs toggle
      @(negedge clk);
      drive(0, 1'b1, 32'h11111111, 32'h22222222, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
      lat = 0;
      while (lat < 40 && !ov32) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk("bp latency", 64'(lat), 64'd4);
      xb = n_xfer32;
      stable  = 1'b1;
      rdy_low = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         drive(0, k[0], $urandom, $urandom, k[1]);
         @(posedge clk);
         #1;
         if (s32 !== 32'h33333333 || co32 !== 1'b0 || of32 !== 1'b0 || ov32 !== 1'b1) stable = 1'b0;
         if (ir32 !== 1'b0) rdy_low = 1'b0;
      end
      chk("bp result held", {63'd0, stable}, 64'd1);
      chk("bp in_ready low", {63'd0, rdy_low}, 64'd1);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
      or32 = 1'b1;
      @(posedge clk);
      #1 or32 = 1'b0;
      chk("bp out_valid drops", {63'd0, ov32}, 64'd0);
      chk("bp in_ready after", {63'd0, ir32}, 64'd1);
      repeat (3) @(negedge clk);
      chk("bp single transfer", 64'(n_xfer32 - xb), 64'd1);

      // Reset during the 2nd ADD cycle
      @(negedge clk);
      drive(0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", {63'd0, ov32}, 64'd0);
      chk("midrst outputs", {30'd0, of32, co32, s32}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("midrst in_ready", {63'd0, ir32}, 64'd1);
      xb = n_xfer32;
      or32 = 1'b1;
      seen_ov = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ov32) seen_ov = 1'b1;
      end
      or32 = 1'b0;
      chk("midrst no stale result", {63'd0, seen_ov}, 64'd0);
      chk("midrst no transfer", 64'(n_xfer32 - xb), 64'd0);

      do_add(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, res, lat);
      chk("post-reset add", {30'd0, res}, {30'd0, 1'b0, 1'b1, 32'h00000000});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
